// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (double-dabble, one bit per clock).
// A four-state FSM (IDLE, CHECK, SHIFT, FINISH) converts a BIN_W-bit unsigned
// value into four BCD digits. Values above 9999 skip the shift loop and flag ovf.
// Optional feature macro: BIN2BCD_SATURATE_EN
//   defined   -> an overflow displays 9,9,9,9
//   undefined -> an overflow displays E,E,E,E
// Display outputs only change on the FINISH edge, so partial results never show.
module bin2bcd_seq #(
  parameter int BIN_W = 14
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [BIN_W-1:0] bin,
  output logic [3:0]       num1,
  output logic [3:0]       num2,
  output logic [3:0]       num3,
  output logic [3:0]       num4,
  output logic             busy,
  output logic             done,
  output logic             ovf
);

  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(BIN_W);

`ifdef BIN2BCD_SATURATE_EN
  localparam logic [3:0] OVF_DIGIT = 4'd9;
`else
  localparam logic [3:0] OVF_DIGIT = 4'hE;
`endif

  typedef enum logic [1:0] {IDLE, CHECK, SHIFT, FINISH} state_t;

  state_t             state_q, state_d;
  logic [BIN_W-1:0]   bin_sr_q;
  logic [15:0]        scratch_q;
  logic [15:0]        scratch_adj;
  logic [CNT_W-1:0]   cnt_q;
  logic               ovf_pend_q;

  // Double-dabble correction: any nibble >= 5 gets +3 before the shift.
  function automatic logic [15:0] dabble_adj(input logic [15:0] s);
    logic [15:0] r;
    r = s;
    for (int i = 0; i < 4; i++) begin
      if (s[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = s[i*4 +: 4] + 4'd3;
    end
    return r;
  endfunction

  // True when the value cannot be shown on four decimal digits.
  function automatic logic is_over(input logic [BIN_W-1:0] v);
    return 32'(v) > 32'd9999;
  endfunction

  assign scratch_adj = dabble_adj(scratch_q);

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = CHECK;
      CHECK:   state_d = is_over(bin_sr_q) ? FINISH : SHIFT;
      SHIFT:   if (cnt_q == CNT_LAST) state_d = FINISH;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath, status flags and held display registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bin_sr_q   <= '0;
      scratch_q  <= '0;
      cnt_q      <= '0;
      ovf_pend_q <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      ovf        <= 1'b0;
      num1       <= '0;
      num2       <= '0;
      num3       <= '0;
      num4       <= '0;
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            bin_sr_q   <= bin;
            scratch_q  <= '0;
            ovf_pend_q <= 1'b0;
            busy       <= 1'b1;
          end
        end
        CHECK: begin
          cnt_q      <= '0;
          ovf_pend_q <= is_over(bin_sr_q);
        end
        SHIFT: begin
          scratch_q <= {scratch_adj[14:0], bin_sr_q[BIN_W-1]};
          bin_sr_q  <= bin_sr_q << 1;
          if (cnt_q != CNT_MAX) cnt_q <= cnt_q + 1'b1;
        end
        FINISH: begin
          if (ovf_pend_q) begin
            num1 <= OVF_DIGIT;
            num2 <= OVF_DIGIT;
            num3 <= OVF_DIGIT;
            num4 <= OVF_DIGIT;
          end else begin
            num1 <= scratch_q[3:0];
            num2 <= scratch_q[7:4];
            num3 <= scratch_q[11:8];
            num4 <= scratch_q[15:12];
          end
          ovf  <= ovf_pend_q;
          done <= 1'b1;
          busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/bin2bcd_seq.md
BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

Interface
REQ-001 Parameter: BIN_W, default 14, width of the binary input; legal range 4..14.
REQ-002 Port: clock  input  1  sole clock; all state changes on its rising edge.
REQ-003 Port: reset_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: start  input  1  request a conversion of bin; sampled only in IDLE.
REQ-005 Port: bin  input  BIN_W  unsigned binary value to convert; sampled on the accepting edge.
REQ-006 Port: num1  output  4  ones digit, BCD; feeds the display's first digit.
REQ-007 Port: num2  output  4  tens digit, BCD.
REQ-008 Port: num3  output  4  hundreds digit, BCD.
REQ-009 Port: num4  output  4  thousands digit, BCD.
REQ-010 Port: busy  output  1  high while a conversion is in progress.
REQ-011 Port: done  output  1  single-cycle pulse marking that num1..num4 and ovf were just updated.
REQ-012 Port: ovf  output  1  last accepted value exceeded 9999; held until the next completion.

Function
REQ-013 The FSM SHALL have four states: IDLE, CHECK, SHIFT, FINISH.
REQ-014 IDLE: on an edge with start=1, the block SHALL latch bin into a shift register, clear the BCD scratch register, set busy=1 and go to CHECK.
REQ-015 CHECK: if the latched value exceeds 9999, the FSM SHALL go to FINISH with the overflow flag set; otherwise it SHALL go to SHIFT with the iteration counter at 0.
REQ-016 SHIFT, per clock (double-dabble):
- add 3 to every scratch BCD nibble that is at least 5;
- shift {scratch, binary} left by 1;
- increment the counter.
REQ-017 SHIFT SHALL exit to FINISH after exactly BIN_W iterations; the counter SHALL NOT wrap.
REQ-018 FINISH: the block SHALL, on a single edge:
- load num1..num4 from the scratch nibbles (or per REQ-026 on overflow);
- load ovf;
- drive done=1 for exactly one cycle and busy=0;
- return to IDLE.
REQ-019 Latency, normal path: done SHALL be high in the cycle following edge k+BIN_W+2, where k is the accepting edge (16 clocks for BIN_W=14).
REQ-020 Latency, overflow path: done SHALL be high in the cycle following edge k+2.
REQ-021 num1..num4 and ovf SHALL change only on the FINISH edge and SHALL otherwise hold, so the display never shows partial results.
REQ-022 start while busy=1, including in the FINISH cycle, SHALL be ignored; no queuing.
REQ-023 start held high continuously SHALL start a new conversion on the first edge back in IDLE, i.e. the edge after done is high.
REQ-024 Each output digit SHALL be in 0..9 whenever ovf=0.

Reset
REQ-025 While reset_n=0, the block SHALL immediately, independent of the clock, force:
- state to IDLE;
- num1..num4 to 0;
- busy, done and ovf to 0;
- the scratch register and counter to 0.
A reset mid-conversion SHALL abort it with no done pulse; the first rising clock edge after reset_n rises SHALL be able to accept start.

Configuration
REQ-026 Macro BIN2BCD_SATURATE_EN:
- defined: an overflow SHALL load 9,9,9,9 into num4..num1 and set ovf=1;
- undefined: an overflow SHALL load 4'hE into all four digits (display shows "EEEE") and set ovf=1.
In both cases, non-overflow results SHALL be identical.

Verification
REQ-027 Reset, then start with bin=1234 -> done 16 clocks after the accepting edge; num4..num1=1,2,3,4; ovf=0; busy high for exactly 16 cycles.
REQ-028 bin=0, then bin=9999 -> digits 0,0,0,0, then 9,9,9,9; ovf=0 for both.
REQ-029 bin=10000 -> done 2 clocks after the accepting edge; ovf=1; digits 9,9,9,9 with BIN2BCD_SATURATE_EN, E,E,E,E without it.
REQ-030 Start bin=42, then pulse start with bin=7 at clock 5 -> the second request is ignored; result 0,0,4,2; exactly one done pulse.
REQ-031 Start bin=5678, assert reset_n=0 at clock 8 -> outputs 0 asynchronously and no done; then start bin=5678 again -> 5,6,7,8 after 16 clocks.
REQ-032 start held high with bin=321 -> back-to-back conversions, one done pulse every 17 clocks; digits stay 0,3,2,1 with no glitch between pulses.
